dcache_assoc: RTL and testbench
===============================

// Module: dcache_assoc
// PURPOSE
//  Parametrised N-way set-associative write-back data cache; successor to the direct-mapped DCache.
//  Sits between the CPU pipeline (single-word load/store) and the higher cache (block refill/evict).
//  Adds: WAYS-way associativity, tree-PLRU replacement, pipeline back-pressure, optional statistics.
// PARAMETERS
//  INDEX       4    set-index bits (2**INDEX sets)
//  WAYS        2    associativity; power of 2, 2..8
//  BLOCK_BITS  512  line size in bits; power of 2, >=64; word = 32 bits
// PORTS
//  clk_i                 in   1           clock, all state on rising edge
//  rst_i                 in   1           asynchronous, active-high reset
//  addr_in_pipeline_i    in   32          CPU byte address; [1:0] ignored
//  data_in_pipeline_i    in   32          CPU store data
//  pipeline_wr_valid_i   in   1           1 = store, 0 = load (qualified by pipeline_valid_i)
//  pipeline_valid_i      in   1           CPU request valid; held until accepted
//  pipeline_ready_o      out  1           cache can accept a request this cycle
//  data_out_pipeline_o   out  32          load data / echoed store data
//  pipeline_valid_o      out  1           1-cycle completion pulse
//  data_in_request_i     in   BLOCK_BITS  refill block from higher cache
//  addr_in_request_i     in   32          refill block address
//  request_valid_i       in   1           refill block valid
//  addr_out_request_o    out  32          block-aligned miss address
//  request_o             out  1           refill request, level
//  evict_i               in   1           higher cache accepted the eviction
//  data_out_evict_o      out  BLOCK_BITS  dirty victim block
//  addr_out_evict_o      out  32          victim block address
//  evict_o               out  1           eviction request, level
// BEHAVIOUR
//  Address: OFF=log2(BLOCK_BITS/8); word=addr[OFF-1:2]; set=addr[OFF+INDEX-1:OFF]; tag=addr[31:OFF+INDEX].
//  Per set/way: valid, dirty, tag, block (flops). Per set: WAYS-1 PLRU bits.
//  FSM: IDLE -> (hit) IDLE | (miss, victim dirty) EVICT | (miss, clean) REFILL; EVICT -> REFILL; REFILL -> RESPOND -> IDLE.
//  pipeline_ready_o = (state==IDLE). Accept = pipeline_valid_i & ready; address/data/rw latched on accept.
//  Hit: pipeline_valid_o next cycle; load returns word, store writes word, sets dirty, echoes data. PLRU updated.
//  Victim: lowest-numbered invalid way, else PLRU way; chosen at accept, fixed until RESPOND.
//  EVICT: evict_o=1, addr_out_evict_o={victim tag,set,OFF'b0}, block on data_out_evict_o, all held until evict_i
//   sampled high; that cycle victim dirty cleared, go REFILL. request_valid_i ignored in EVICT.
//  REFILL: request_o=1, addr_out_request_o={tag,set,OFF'b0} held; complete only when request_valid_i and
//   addr_in_request_i[31:OFF]==addr_out_request_o[31:OFF]; mismatched responses ignored. Line installed valid, clean.
//  RESPOND: access applied to installed line (store merges word, sets dirty); pipeline_valid_o=1; PLRU updated.
//  Miss latency = evict wait + refill wait + 2 cycles from accept to pipeline_valid_o.
//  evict_i outside EVICT and request_valid_i outside REFILL: no effect.
//  Reset (any state, incl. mid-evict/refill): valid, dirty, PLRU cleared; state IDLE; request_o, evict_o,
//   pipeline_valid_o=0; address/data outputs 0; in-flight access dropped, no write-back, no response.
//  data_out_pipeline_o holds last value between pulses.
// CONFIGURATION
//  DCACHE_STATS_EN defined: extra outputs hit_count_o, miss_count_o, evict_count_o (32 b each), saturating
//   at 32'hFFFF_FFFF; +1 on hit accept, miss accept, evict_i handshake; cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package dcache_assoc_pkg: state_t enum (IDLE/EVICT/REFILL/RESPOND), WORD_BITS=32, functions for
//   offset/index/tag widths and block-aligned address.
//  Sub-module dcache_plru: tree-PLRU per set; inputs set, touched way, update; output victim way.
// TESTING  (INDEX=4, WAYS=2, BLOCK_BITS=512: set=addr[9:6], tag=addr[31:10])
//  1 Cold load 0x044 -> request_o, addr_out_request_o=0x040, no evict_o; refill word1=0xDEADBEEF ->
//    pipeline_valid_o with 0xDEADBEEF; reload 0x044 -> hit, valid 1 cycle after accept, no request_o.
//  2 Store 0x044=0x12345678 (hit) -> ack next cycle; load 0x044 -> 0x12345678; no higher-cache traffic.
//  3 Load 0x040, 0x440 (fill both ways), load 0x040, then load 0x840 -> way of 0x440 replaced, clean so
//    no evict_o; load 0x040 still hits.
//  4 Store 0x440=0xCAFEF00D, load 0x040, load 0x840 -> evict_o addr 0x440 with word0=0xCAFEF00D held
//    3 cycles until evict_i, then request_o addr 0x840.
//  5 In REFILL drive request_valid_i with addr 0x1000 -> ignored, request_o stays; assert rst_i mid-REFILL ->
//    request_o=0, ready=1, prior hits now miss.
//  6 1024 random loads/stores over 64 blocks vs. reference memory model with ack-delay 0..4 cycles ->
//    every load matches; with DCACHE_STATS_EN hit+miss=1024.

Source files
------------

// File: rtl/dcache_assoc_pkg.sv
// Shared state encoding and address-geometry helpers for the set-associative data cache.
package dcache_assoc_pkg;

    typedef enum logic [1:0] {IDLE, EVICT, REFILL, RESPOND} state_t;

    localparam int unsigned WORD_BITS = 32;

    function automatic int unsigned off_bits(input int unsigned block_bits);
        return $clog2(block_bits / 8);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned index, input int unsigned block_bits);
        return 32 - index - off_bits(block_bits);
    endfunction

    function automatic logic [31:0] block_align(input logic [31:0] addr, input int unsigned off);
        return (addr >> off) << off;
    endfunction

endpackage

// File: rtl/dcache_plru.sv
// Tree pseudo-LRU state for every set: WAYS-1 heap-ordered node bits per set.
// A node bit points toward the less recently used subtree (0 = left, 1 = right).
module dcache_plru
    import dcache_assoc_pkg::*;
#(
    parameter int unsigned INDEX = 4,
    parameter int unsigned WAYS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX-1:0]        set,
    input  logic [$clog2(WAYS)-1:0] touched_way,
    input  logic                    update,
    output logic [$clog2(WAYS)-1:0] victim_way
);

    localparam int unsigned LEVELS = $clog2(WAYS);
    localparam int unsigned NODES  = WAYS - 1;
    localparam int unsigned SETS   = 2 ** INDEX;

    logic [NODES-1:0] tree_q [SETS];
    logic [NODES-1:0] tree_d;

    always_comb begin
        int unsigned      node;
        logic             dir;
        logic [NODES-1:0] mask;
        victim_way = '0;
        node       = 0;
        dir        = 1'b0;
        mask       = '0;
        for (int l = 0; l < int'(LEVELS); l++) begin
            mask       = NODES'(1) << node;
            dir        = |(tree_q[set] & mask);
            victim_way = (victim_way << 1) | LEVELS'(dir);
            node       = 2 * node + 1 + {31'b0, dir};
        end
    end

    // Walk the touched way's path and turn every node on it to face away from that way.
    always_comb begin
        int unsigned      node;
        logic             dir;
        logic [NODES-1:0] mask;
        tree_d = tree_q[set];
        node   = 0;
        dir    = 1'b0;
        mask   = '0;
        for (int l = 0; l < int'(LEVELS); l++) begin
            mask   = NODES'(1) << node;
            dir    = |(touched_way & (LEVELS'(1) << (LEVELS - 1 - l)));
            tree_d = dir ? (tree_d & ~mask) : (tree_d | mask);
            node   = 2 * node + 1 + {31'b0, dir};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                tree_q[s] <= '0;
            end
        end else if (update) begin
            tree_q[set] <= tree_d;
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back data cache with tree-PLRU replacement and back-pressure.
// Define DCACHE_STATS_EN to add saturating hit/miss/evict counters.
module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int unsigned INDEX      = 4,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned BLOCK_BITS = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           addr_in_pipeline_i,
    input  logic [31:0]           data_in_pipeline_i,
    input  logic                  pipeline_wr_valid_i,
    input  logic                  pipeline_valid_i,
    output logic                  pipeline_ready_o,
    output logic [31:0]           data_out_pipeline_o,
    output logic                  pipeline_valid_o,
    input  logic [BLOCK_BITS-1:0] data_in_request_i,
    input  logic [31:0]           addr_in_request_i,
    input  logic                  request_valid_i,
    output logic [31:0]           addr_out_request_o,
    output logic                  request_o,
    input  logic                  evict_i,
    output logic [BLOCK_BITS-1:0] data_out_evict_o,
    output logic [31:0]           addr_out_evict_o,
    output logic                  evict_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o,
    output logic [31:0]           evict_count_o
`endif
);

    localparam int unsigned OFF   = off_bits(BLOCK_BITS);
    localparam int unsigned TAGW  = tag_bits(INDEX, BLOCK_BITS);
    localparam int unsigned SETS  = 2 ** INDEX;
    localparam int unsigned WAYW  = $clog2(WAYS);
    localparam int unsigned WSELW = OFF - 2;

    logic                  valid_q [SETS][WAYS];
    logic                  dirty_q [SETS][WAYS];
    logic [TAGW-1:0]       tag_q   [SETS][WAYS];
    logic [BLOCK_BITS-1:0] data_q  [SETS][WAYS];

    state_t          state_q;
    logic [31:2]     lat_addr_q;
    logic [31:0]     lat_data_q;
    logic            lat_wr_q;
    logic [WAYW-1:0] victim_q;

    logic                  accept, hit, inv_found, refill_done, plru_update;
    logic [WAYW-1:0]       hit_way, inv_way, plru_way, victim, plru_touch;
    logic [INDEX-1:0]      req_set, lat_set, plru_set;
    logic [TAGW-1:0]       req_tag, lat_tag;
    logic [WSELW-1:0]      req_word, lat_word;
    logic [31:0]           hit_word, refill_word;
    logic [BLOCK_BITS-1:0] line_merged;
    logic                  unused_bits;

    assign req_set  = addr_in_pipeline_i[OFF+INDEX-1:OFF];
    assign req_tag  = addr_in_pipeline_i[31:OFF+INDEX];
    assign req_word = addr_in_pipeline_i[OFF-1:2];
    assign lat_set  = lat_addr_q[OFF+INDEX-1:OFF];
    assign lat_tag  = lat_addr_q[31:OFF+INDEX];
    assign lat_word = lat_addr_q[OFF-1:2];

    assign unused_bits = ^{addr_in_pipeline_i[1:0], addr_in_request_i[OFF-1:0]};

    assign pipeline_ready_o = (state_q == IDLE);
    assign accept           = pipeline_valid_i && pipeline_ready_o;
    assign refill_done      = (state_q == REFILL) && request_valid_i &&
                              (addr_in_request_i[31:OFF] == lat_addr_q[31:OFF]);

    // Descending scan so the lowest-numbered matching or invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
            if (!valid_q[req_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WAYW'(w);
            end
        end
    end

    assign victim      = inv_found ? inv_way : plru_way;
    assign hit_word    = data_q[req_set][hit_way][req_word*WORD_BITS +: WORD_BITS];
    assign refill_word = data_in_request_i[lat_word*WORD_BITS +: WORD_BITS];

    always_comb begin
        line_merged = data_in_request_i;
        if (lat_wr_q) begin
            line_merged[lat_word*WORD_BITS +: WORD_BITS] = lat_data_q;
        end
    end

    assign plru_set    = pipeline_ready_o ? req_set : lat_set;
    assign plru_touch  = pipeline_ready_o ? hit_way : victim_q;
    assign plru_update = (accept && hit) || (state_q == RESPOND);

    dcache_plru #(
        .INDEX(INDEX),
        .WAYS (WAYS)
    ) u_plru (
        .clk        (clk_i),
        .rst        (rst_i),
        .set        (plru_set),
        .touched_way(plru_touch),
        .update     (plru_update),
        .victim_way (plru_way)
    );

    // Line payload and tags carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (accept && hit && pipeline_wr_valid_i) begin
            data_q[req_set][hit_way][req_word*WORD_BITS +: WORD_BITS] <= data_in_pipeline_i;
        end
        if (refill_done) begin
            data_q[lat_set][victim_q] <= line_merged;
            tag_q[lat_set][victim_q]  <= lat_tag;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q             <= IDLE;
            lat_addr_q          <= '0;
            lat_data_q          <= '0;
            lat_wr_q            <= 1'b0;
            victim_q            <= '0;
            pipeline_valid_o    <= 1'b0;
            data_out_pipeline_o <= '0;
            request_o           <= 1'b0;
            addr_out_request_o  <= '0;
            evict_o             <= 1'b0;
            addr_out_evict_o    <= '0;
            data_out_evict_o    <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            pipeline_valid_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        lat_addr_q <= addr_in_pipeline_i[31:2];
                        lat_data_q <= data_in_pipeline_i;
                        lat_wr_q   <= pipeline_wr_valid_i;
                        if (hit) begin
                            pipeline_valid_o <= 1'b1;
                            if (pipeline_wr_valid_i) begin
                                data_out_pipeline_o       <= data_in_pipeline_i;
                                dirty_q[req_set][hit_way] <= 1'b1;
                            end else begin
                                data_out_pipeline_o <= hit_word;
                            end
                        end else begin
                            victim_q <= victim;
                            if (valid_q[req_set][victim] && dirty_q[req_set][victim]) begin
                                state_q          <= EVICT;
                                evict_o          <= 1'b1;
                                addr_out_evict_o <= {tag_q[req_set][victim], req_set, {OFF{1'b0}}};
                                data_out_evict_o <= data_q[req_set][victim];
                            end else begin
                                state_q            <= REFILL;
                                request_o          <= 1'b1;
                                addr_out_request_o <= block_align(addr_in_pipeline_i, OFF);
                            end
                        end
                    end
                end
                EVICT: begin
                    if (evict_i) begin
                        evict_o                    <= 1'b0;
                        dirty_q[lat_set][victim_q] <= 1'b0;
                        state_q                    <= REFILL;
                        request_o                  <= 1'b1;
                        addr_out_request_o         <= block_align({lat_addr_q, 2'b00}, OFF);
                    end
                end
                REFILL: begin
                    // Store data is merged at install, so the line lands dirty iff this was a store.
                    if (refill_done) begin
                        request_o                  <= 1'b0;
                        valid_q[lat_set][victim_q] <= 1'b1;
                        dirty_q[lat_set][victim_q] <= lat_wr_q;
                        pipeline_valid_o           <= 1'b1;
                        data_out_pipeline_o        <= lat_wr_q ? lat_data_q : refill_word;
                        state_q                    <= RESPOND;
                    end
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_count_o   <= '0;
            miss_count_o  <= '0;
            evict_count_o <= '0;
        end else begin
            if (accept && hit && (hit_count_o != 32'hFFFF_FFFF)) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            if (accept && !hit && (miss_count_o != 32'hFFFF_FFFF)) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
            if ((state_q == EVICT) && evict_i && (evict_count_o != 32'hFFFF_FFFF)) begin
                evict_count_o <= evict_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (INDEX=4, WAYS=2, 512-bit lines) with a modelled higher cache.
// Honours DCACHE_STATS_EN when the design is built with it.
`timescale 1ns/1ps
module tb_dcache_assoc;

    localparam int unsigned BB = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr_in, data_in;
    logic          wr_v, p_valid, ready, p_valid_o;
    logic [31:0]   data_out;
    logic [BB-1:0] req_data;
    logic [31:0]   req_addr;
    logic          req_valid;
    logic [31:0]   addr_out_req;
    logic          request;
    logic          evict_ack;
    logic [BB-1:0] ev_data;
    logic [31:0]   ev_addr;
    logic          evict;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_cnt, miss_cnt, ev_cnt;
    logic [31:0]   h0, m0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [1024];  // higher-cache contents, updated by write-backs
    logic [31:0] ref_mem [1024];  // what the CPU should read back

    logic [31:0] rd, last_req_addr, last_ev_addr, last_ev_word0;
    int          lat, nev, nreq, ev_cycles;

    always #5 clk = ~clk;

    dcache_assoc #(
        .INDEX     (4),
        .WAYS      (2),
        .BLOCK_BITS(BB)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .addr_in_pipeline_i (addr_in),
        .data_in_pipeline_i (data_in),
        .pipeline_wr_valid_i(wr_v),
        .pipeline_valid_i   (p_valid),
        .pipeline_ready_o   (ready),
        .data_out_pipeline_o(data_out),
        .pipeline_valid_o   (p_valid_o),
        .data_in_request_i  (req_data),
        .addr_in_request_i  (req_addr),
        .request_valid_i    (req_valid),
        .addr_out_request_o (addr_out_req),
        .request_o          (request),
        .evict_i            (evict_ack),
        .data_out_evict_o   (ev_data),
        .addr_out_evict_o   (ev_addr),
        .evict_o            (evict)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o        (hit_cnt),
        .miss_count_o       (miss_cnt),
        .evict_count_o      (ev_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU access; the higher cache answers each evict/refill after 'dly' extra cycles.
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d, input int dly);
        int cnt;
        int guard;
        cnt = 0; nev = 0; nreq = 0; ev_cycles = 0; lat = 0;
        guard = 0;
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        addr_in = a; data_in = d; wr_v = w; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        lat = 1;
        while (!p_valid_o && lat < 100) begin
            if (evict) begin
                ev_cycles++;
                last_ev_addr  = ev_addr;
                last_ev_word0 = ev_data[31:0];
                if (cnt == dly) begin
                    for (int i = 0; i < 16; i++) mem[ev_addr[11:2] + i] = ev_data[i*32 +: 32];
                    evict_ack = 1'b1;
                    nev++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else if (request) begin
                last_req_addr = addr_out_req;
                if (cnt == dly) begin
                    req_addr = addr_out_req;
                    for (int i = 0; i < 16; i++) req_data[i*32 +: 32] = mem[addr_out_req[11:2] + i];
                    req_valid = 1'b1;
                    nreq++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            @(negedge clk);
            evict_ack = 1'b0;
            req_valid = 1'b0;
            lat++;
        end
        check("response_seen", {31'b0, p_valid_o}, 32'd1);
        rd = data_out;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  rtag;
        logic [3:0]  rset, rword;
        logic        w;
        int          dly;

        rst = 1'b1; addr_in = '0; data_in = '0; wr_v = 1'b0; p_valid = 1'b0;
        req_data = '0; req_addr = '0; req_valid = 1'b0; evict_ack = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E37_79B1;
        mem[32'h044 >> 2] = 32'hDEAD_BEEF;
        mem[32'h040 >> 2] = 32'h0040_0040;
        mem[32'h440 >> 2] = 32'h4400_4400;
        mem[32'h840 >> 2] = 32'h8400_8400;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_request", {31'b0, request}, 32'd0);
        check("rst_evict", {31'b0, evict}, 32'd0);
        check("rst_pvalid", {31'b0, p_valid_o}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: cold load then reload hit
        access(32'h044, 1'b0, 32'h0, 0);
        check("t1_miss_nreq", 32'(nreq), 32'd1);
        check("t1_miss_addr", last_req_addr, 32'h040);
        check("t1_miss_nev", 32'(nev), 32'd0);
        check("t1_miss_data", rd, 32'hDEAD_BEEF);
        check("t1_miss_lat", 32'(lat), 32'd2);
        access(32'h044, 1'b0, 32'h0, 0);
        check("t1_hit_lat", 32'(lat), 32'd1);
        check("t1_hit_nreq", 32'(nreq), 32'd0);
        check("t1_hit_data", rd, 32'hDEAD_BEEF);

        // 2: store hit then load it back
        access(32'h044, 1'b1, 32'h1234_5678, 0);
        check("t2_st_lat", 32'(lat), 32'd1);
        check("t2_st_echo", rd, 32'h1234_5678);
        check("t2_st_traffic", 32'(nreq + nev), 32'd0);
        @(negedge clk);
        check("t2_pulse_1cyc", {31'b0, p_valid_o}, 32'd0);
        check("t2_hold_data", data_out, 32'h1234_5678);
        access(32'h044, 1'b0, 32'h0, 0);
        check("t2_ld_data", rd, 32'h1234_5678);
        check("t2_ld_traffic", 32'(nreq + nev), 32'd0);

        // 3: fill both ways of set 1, clean replacement of 0x440 by 0x840
        access(32'h040, 1'b0, 32'h0, 0);
        check("t3_040_hit", 32'(lat), 32'd1);
        access(32'h440, 1'b0, 32'h0, 0);
        check("t3_440_nreq", 32'(nreq), 32'd1);
        check("t3_440_data", rd, 32'h4400_4400);
        access(32'h040, 1'b0, 32'h0, 0);
        check("t3_040_data", rd, 32'h0040_0040);
        access(32'h840, 1'b0, 32'h0, 0);
        check("t3_840_nev", 32'(nev), 32'd0);
        check("t3_840_addr", last_req_addr, 32'h840);
        check("t3_840_data", rd, 32'h8400_8400);
        access(32'h040, 1'b0, 32'h0, 0);
        check("t3_040_still_hit", 32'(lat), 32'd1);
        check("t3_040_still_data", rd, 32'h0040_0040);

        // 4: dirty 0x440 is evicted by 0x840 with a 2-cycle slow higher cache
        access(32'h440, 1'b1, 32'hCAFE_F00D, 0);
        check("t4_st_nev", 32'(nev), 32'd0);
        check("t4_st_lat", 32'(lat), 32'd2);
        check("t4_st_echo", rd, 32'hCAFE_F00D);
        access(32'h040, 1'b0, 32'h0, 0);
        check("t4_040_hit", 32'(lat), 32'd1);
        access(32'h840, 1'b0, 32'h0, 2);
        check("t4_nev", 32'(nev), 32'd1);
        check("t4_ev_addr", last_ev_addr, 32'h440);
        check("t4_ev_word0", last_ev_word0, 32'hCAFE_F00D);
        check("t4_ev_cycles", 32'(ev_cycles), 32'd3);
        check("t4_req_addr", last_req_addr, 32'h840);
        check("t4_data", rd, 32'h8400_8400);
        check("t4_lat", 32'(lat), 32'd7);
        check("t4_writeback", mem[32'h440 >> 2], 32'hCAFE_F00D);

        // 5: mismatched refill ignored, then reset mid-refill
        @(negedge clk);
        addr_in = 32'h0C4; wr_v = 1'b0; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        check("t5_request", {31'b0, request}, 32'd1);
        check("t5_req_addr", addr_out_req, 32'h0C0);
        req_addr = 32'h1000; req_data = '1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_wrong_ignored", {31'b0, request}, 32'd1);
        check("t5_no_resp", {31'b0, p_valid_o}, 32'd0);
        rst = 1'b1;
        #1;
        check("t5_rst_request", {31'b0, request}, 32'd0);
        check("t5_rst_ready", {31'b0, ready}, 32'd1);
        check("t5_rst_req_addr", addr_out_req, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(32'h044, 1'b0, 32'h0, 0);
        check("t5_now_miss", 32'(nreq), 32'd1);
        check("t5_dirty_dropped", rd, 32'hDEAD_BEEF);

        // 6: random traffic against a reference memory
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
`ifdef DCACHE_STATS_EN
        h0 = hit_cnt;
        m0 = miss_cnt;
`endif
        for (int n = 0; n < 1024; n++) begin
            rtag  = 2'($urandom_range(0, 3));
            rset  = 4'($urandom_range(0, 15));
            rword = 4'($urandom_range(0, 15));
            a     = {20'b0, rtag, rset, rword, 2'b00};
            w     = 1'($urandom_range(0, 1));
            d     = $urandom;
            dly   = $urandom_range(0, 4);
            access(a, w, d, dly);
            if (w) begin
                ref_mem[a[11:2]] = d;
                check("rand_store_echo", rd, d);
            end else begin
                check("rand_load", rd, ref_mem[a[11:2]]);
            end
        end
`ifdef DCACHE_STATS_EN
        check("stats_hit_plus_miss", (hit_cnt - h0) + (miss_cnt - m0), 32'd1024);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
